// File: rtl/rtc_write_cycle.sv
// rtl/rtc_write_cycle.sv - write-cycle sequencer for the external RTC multiplexed AD bus
//
// Latches one register address and one data byte on an accepted start, then
// walks an address phase and a data phase, each made of setup / strobe / hold
// sub-phases, and finishes with a one-clock DONE. Every output is a flop
// loaded from a decode of the next state, so nothing combinational reaches
// the pins.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    one-clock write request, honoured only in IDLE
//   addr_in  RTC register address, captured on accepted start
//   data_in  data byte, captured on accepted start
//   ADw      0 = address phase, 1 = data phase / idle
//   RDw      read strobe, held inactive (1)
//   CSw      chip select, active-low
//   WRw      write strobe, active-low
//   selw     write path owns the bus (accepted start through DONE)
//   bus_out  byte driven onto the AD bus
//   bus_oe   tri-state enable for bus_out
//   done     one-clock pulse at end of cycle
module rtc_write_cycle #(
    parameter int T_SU = 2,
    parameter int T_PW = 4,
    parameter int T_HD = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] addr_in,
    input  logic [7:0] data_in,
    output logic       ADw,
    output logic       RDw,
    output logic       CSw,
    output logic       WRw,
    output logic       selw,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       done
);

    localparam logic [7:0] SU_LEN = 8'(T_SU);
    localparam logic [7:0] PW_LEN = 8'(T_PW);
    localparam logic [7:0] HD_LEN = 8'(T_HD);

    typedef enum logic [2:0] {
        IDLE,
        A_SU,
        A_PW,
        A_HD,
        D_SU,
        D_PW,
        D_HD,
        DONE
    } state_t;

    state_t     state;
    state_t     nxt;
    logic [7:0] cnt;
    logic [7:0] nxt_cnt;
    logic [7:0] addr_l;
    logic [7:0] data_l;
    logic       accept;

    assign accept = (state == IDLE) && start;

    // Each phase loads its length on entry; the phase ends on the clock
    // where the counter reads 1.
    always_comb begin
        nxt     = state;
        nxt_cnt = cnt;
        if (state == IDLE) begin
            if (start) begin
                nxt     = A_SU;
                nxt_cnt = SU_LEN;
            end
        end else if (cnt > 8'd1) begin
            nxt_cnt = cnt - 8'd1;
        end else begin
            case (state)
                A_SU:    begin nxt = A_PW; nxt_cnt = PW_LEN; end
                A_PW:    begin nxt = A_HD; nxt_cnt = HD_LEN; end
                A_HD:    begin nxt = D_SU; nxt_cnt = SU_LEN; end
                D_SU:    begin nxt = D_PW; nxt_cnt = PW_LEN; end
                D_PW:    begin nxt = D_HD; nxt_cnt = HD_LEN; end
                D_HD:    begin nxt = DONE; nxt_cnt = 8'd1;   end
                default: begin nxt = IDLE; nxt_cnt = 8'd0;   end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            addr_l  <= 8'd0;
            data_l  <= 8'd0;
            ADw     <= 1'b1;
            RDw     <= 1'b1;
            CSw     <= 1'b1;
            WRw     <= 1'b1;
            selw    <= 1'b0;
            bus_out <= 8'd0;
            bus_oe  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= nxt_cnt;
            if (accept) begin
                addr_l <= addr_in;
                data_l <= data_in;
            end
            ADw    <= !(nxt inside {A_SU, A_PW, A_HD});
            RDw    <= 1'b1;
            CSw    <= !(nxt inside {A_PW, D_PW});
            WRw    <= !(nxt inside {A_PW, D_PW});
            selw   <= (nxt != IDLE);
            bus_oe <= (nxt != IDLE) && (nxt != DONE);
            done   <= (nxt == DONE);
            // The latch is written on the same edge, so the address comes
            // straight from the input here. Outside these two events the
            // bus holds, keeping it stable for the whole of each phase.
            if (accept) begin
                bus_out <= addr_in;
            end else if (state == A_HD && nxt == D_SU) begin
                bus_out <= data_l;
            end
        end
    end

endmodule

// File: tb/tb_rtc_write_cycle.sv
// tb/tb_rtc_write_cycle.sv - randomized self-checking bench for rtc_write_cycle
module tb_rtc_write_cycle;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start;
    logic [7:0] addr_in;
    logic [7:0] data_in;

    logic       ad  [3];
    logic       rd  [3];
    logic       cs  [3];
    logic       wr  [3];
    logic       sel [3];
    logic       oe  [3];
    logic       dn  [3];
    logic [7:0] bus [3];

    int su_of [3] = '{2, 1, 1};
    int pw_of [3] = '{4, 1, 255};
    int hd_of [3] = '{2, 1, 1};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rtc_write_cycle u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .addr_in(addr_in), .data_in(data_in),
        .ADw(ad[0]), .RDw(rd[0]), .CSw(cs[0]), .WRw(wr[0]), .selw(sel[0]),
        .bus_out(bus[0]), .bus_oe(oe[0]), .done(dn[0])
    );

    rtc_write_cycle #(.T_SU(1), .T_PW(1), .T_HD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .addr_in(addr_in), .data_in(data_in),
        .ADw(ad[1]), .RDw(rd[1]), .CSw(cs[1]), .WRw(wr[1]), .selw(sel[1]),
        .bus_out(bus[1]), .bus_oe(oe[1]), .done(dn[1])
    );

    rtc_write_cycle #(.T_SU(1), .T_PW(255), .T_HD(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .addr_in(addr_in), .data_in(data_in),
        .ADw(ad[2]), .RDw(rd[2]), .CSw(cs[2]), .WRw(wr[2]), .selw(sel[2]),
        .bus_out(bus[2]), .bus_oe(oe[2]), .done(dn[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input int d, input logic e_ad, input logic e_cs, input logic e_sel,
                               input logic e_oe, input logic e_dn, input logic [7:0] e_bus,
                               input string ctx);
        check($sformatf("%s d%0d ADw", ctx, d), ad[d], e_ad);
        check($sformatf("%s d%0d RDw", ctx, d), rd[d], 1'b1);
        check($sformatf("%s d%0d CSw", ctx, d), cs[d], e_cs);
        check($sformatf("%s d%0d WRw", ctx, d), wr[d], e_cs);
        check($sformatf("%s d%0d selw", ctx, d), sel[d], e_sel);
        check($sformatf("%s d%0d bus_oe", ctx, d), oe[d], e_oe);
        check($sformatf("%s d%0d done", ctx, d), dn[d], e_dn);
        if (e_oe) check($sformatf("%s d%0d bus", ctx, d), bus[d], e_bus);
    endtask

    // Expected waveform of a whole write from the clock after the accepting
    // edge: offset t into a cycle of 2L+1 clocks, L = setup+strobe+hold.
    // hold keeps start asserted; inj_t pulses a foreign start mid-cycle.
    task automatic check_cycle(input int d, input logic [7:0] a, input logic [7:0] dt,
                               input bit hold, input int inj_t, input string ctx);
        int  su = su_of[d];
        int  pw = pw_of[d];
        int  len = su + pw_of[d] + hd_of[d];
        int  r;
        bit  aph;
        bit  strobe;
        for (int t = 0; t <= 2 * len; t++) begin
            @(negedge clk);
            if (t == 2 * len) begin
                check_state(d, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, $sformatf("%s t%0d", ctx, t));
            end else begin
                aph    = (t < len);
                r      = t % len;
                strobe = (r >= su) && (r < su + pw);
                check_state(d, !aph, !strobe, 1'b1, 1'b1, 1'b0, aph ? a : dt,
                            $sformatf("%s t%0d", ctx, t));
            end
            if (!hold) begin
                start[d] = (t == inj_t);
                if (t == inj_t) begin
                    addr_in = 8'h55;
                    data_in = 8'(~dt);
                end
            end
        end
        @(negedge clk);
        check_state(d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, {ctx, " gap"});
    endtask

    task automatic kick(input int d, input logic [7:0] a, input logic [7:0] dt);
        @(posedge clk);
        #1;
        start[d] = 1'b1;
        addr_in  = a;
        data_in  = dt;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        addr_in  = 8'($urandom);
        data_in  = 8'($urandom);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] dt;
        rst_n   = 1'b0;
        start   = 3'b000;
        addr_in = 8'h00;
        data_in = 8'h00;

        #12;
        for (int d = 0; d < 3; d++) begin
            check_state(d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "reset");
            check($sformatf("reset d%0d bus", d), bus[d], 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) check_state(d, 1'b1, 1'b1, 1'b0, 0, 0, 8'h00, "post-reset idle");
        end

        kick(0, 8'h21, 8'hA5);
        check_cycle(0, 8'h21, 8'hA5, 1'b0, -1, "single");

        kick(0, 8'h21, 8'hA5);
        check_cycle(0, 8'h21, 8'hA5, 1'b0, su_of[0] + 1, "busy-start");
        @(negedge clk);
        check_state(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "busy-start after");

        for (int i = 0; i < 4; i++) begin
            a  = 8'($urandom);
            dt = 8'($urandom);
            kick(0, a, dt);
            check_cycle(0, a, dt, 1'b0, int'($urandom_range(0, 15)), $sformatf("rand0 #%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            a  = 8'($urandom);
            dt = 8'($urandom);
            kick(1, a, dt);
            check_cycle(1, a, dt, 1'b0, -1, $sformatf("rand1 #%0d", i));
        end

        a  = 8'($urandom);
        dt = 8'($urandom);
        kick(2, a, dt);
        check_cycle(2, a, dt, 1'b0, int'($urandom_range(0, 400)), "pw255");

        for (int d = 0; d < 2; d++) begin
            @(posedge clk);
            #1;
            start[d] = 1'b1;
            a        = 8'($urandom);
            dt       = 8'($urandom);
            addr_in  = a;
            data_in  = dt;
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                check_cycle(d, a, dt, 1'b1, -1, $sformatf("b2b #%0d", k));
                a       = 8'($urandom);
                dt      = 8'($urandom);
                addr_in = a;
                data_in = dt;
            end
            start[d] = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check_state(d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "b2b end");
        end

        a  = 8'($urandom);
        dt = 8'($urandom);
        kick(0, a, dt);
        repeat (su_of[0] + pw_of[0] + hd_of[0] + su_of[0] + 2) @(negedge clk);
        check("abort pre CSw", cs[0], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort CSw", cs[0], 1'b1);
        check("abort WRw", wr[0], 1'b1);
        check("abort bus_oe", oe[0], 1'b0);
        check("abort selw", sel[0], 1'b0);
        check("abort done", dn[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("abort no done", dn[0], 1'b0);
            check("abort idle selw", sel[0], 1'b0);
        end
        a  = 8'($urandom);
        dt = 8'($urandom);
        kick(0, a, dt);
        check_cycle(0, a, dt, 1'b0, -1, "after abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
